// File: rtl/toggle_period_monitor.sv
// toggle_period_monitor
//   Receive-side checker for free-running toggle signals. It measures the
//   clk-cycle spacing between successive toggle_in transitions (the
//   half-period) and compares each measurement against EXP_PERIOD +/- TOL.
//   Lock is declared after LOCK_COUNT consecutive in-window measurements.
//   Deviations and timeouts while locked raise err and bump a saturating
//   error count.
//
//   Build option: define SYNC_EN to pass toggle_in through a 2-flop
//   synchronizer ahead of the edge register (edge-to-period_valid latency 3).
//   Without it toggle_in is registered once (latency 1); use that only for
//   sources synchronous to clk. Measured values are the same in both builds.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous reset, active low
//   en           in   monitor enable
//   toggle_in    in   toggling signal under test
//   half_period  out  last measured half-period in clk cycles (CNT_W bits)
//   period_valid out  1-cycle pulse when half_period updates
//   locked       out  high while locked (follows the state by one cycle)
//   err          out  1-cycle pulse on window violation or timeout while locked
//   err_count    out  errors seen, saturates at 255
//
// States
//   IDLE      | monitor disabled, counters cleared
//   WAIT_EDGE | waiting for a reference edge, no measurement
//   ACQUIRE   | measuring, counting consecutive in-window periods
//   LOCKED    | measuring, violations and timeouts raise err
module toggle_period_monitor #(
  parameter int CNT_W      = 16,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             toggle_in,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_count
);

  localparam int LO_I = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam int HI_I = EXP_PERIOD + TOL;
  localparam logic [CNT_W:0] WIN_LO = LO_I[CNT_W:0];
  localparam logic [CNT_W:0] WIN_HI = HI_I[CNT_W:0];
  localparam logic [4:0]     LOCK_N = LOCK_COUNT[4:0];

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    ACQUIRE   = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       match_q, match_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             samp_q, prev_q;

`ifdef SYNC_EN
  logic sync1_q, sync2_q;
`endif

  logic             edge_det;
  logic [CNT_W-1:0] meas;
  logic             in_win;
  logic             timeout;
  logic [4:0]       match_inc;
  logic [7:0]       err_count_inc;

  assign edge_det = samp_q ^ prev_q;
  // Saturating cnt+1 doubles as the measurement and the counter's next value.
  assign meas     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign in_win   = ({1'b0, meas} >= WIN_LO) && ({1'b0, meas} <= WIN_HI);
  // Fires as cnt steps onto EXP_PERIOD+TOL: an edge in the next cycle could
  // no longer land inside the window.
  assign timeout  = !edge_det && ({1'b0, meas} == WIN_HI);
  assign match_inc     = {1'b0, match_q} + 5'd1;
  assign err_count_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    cnt_d          = edge_det ? '0 : meas;
    match_d        = match_q;
    half_period_d  = half_period_q;
    period_valid_d = 1'b0;
    err_d          = 1'b0;
    err_count_d    = err_count_q;
    locked_d       = en && (state_q == LOCKED);

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      match_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_EDGE;
          cnt_d   = '0;
          match_d = '0;
        end
        WAIT_EDGE: begin
          match_d = '0;
          if (edge_det) state_d = ACQUIRE;
        end
        ACQUIRE: begin
          if (edge_det) begin
            half_period_d  = meas;
            period_valid_d = 1'b1;
            if (in_win) begin
              match_d = match_inc[3:0];
              if (match_inc >= LOCK_N) state_d = LOCKED;
            end else begin
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          if (edge_det) begin
            half_period_d  = meas;
            period_valid_d = 1'b1;
            if (!in_win) begin
              err_d       = 1'b1;
              err_count_d = err_count_inc;
              match_d     = '0;
              state_d     = ACQUIRE;
            end
          end else if (timeout) begin
            err_d       = 1'b1;
            err_count_d = err_count_inc;
            match_d     = '0;
            state_d     = WAIT_EDGE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      match_q        <= '0;
      half_period_q  <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
      err_count_q    <= '0;
      samp_q         <= 1'b0;
      prev_q         <= 1'b0;
`ifdef SYNC_EN
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      match_q        <= match_d;
      half_period_q  <= half_period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      err_q          <= err_d;
      err_count_q    <= err_count_d;
      prev_q         <= samp_q;
`ifdef SYNC_EN
      sync1_q        <= toggle_in;
      sync2_q        <= sync1_q;
      samp_q         <= sync2_q;
`else
      samp_q         <= toggle_in;
`endif
    end
  end

  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_toggle_period_monitor.sv
module tb_toggle_period_monitor;

  localparam int CNT_W = 16;
  localparam int EXP   = 10;
  localparam int TOL   = 1;
  localparam int LC    = 4;
`ifdef SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             toggle_in = 1'b0;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic             locked;
  logic             err;
  logic [7:0]       err_count;

  toggle_period_monitor #(.CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_COUNT(LC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .toggle_in(toggle_in),
    .half_period(half_period), .period_valid(period_valid), .locked(locked),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit pv;
    bit er;
    int hp;
    int ec;
    bit lk;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Reference model: mode 0 idle, 1 waiting for first edge, 2 acquiring, 3 locked.
  int mode = 0;
  int match = 0;
  int m_ec = 0;
  int m_hp = 0;
  int last_t = 0;

  function automatic bit in_window(int g);
    return (g >= EXP - TOL) && (g <= EXP + TOL);
  endfunction

  function automatic int sat_inc(int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // gap: cycles since previous toggle; tcyc: cycle at which this toggle is driven.
  task automatic model_edge(input int gap, input int tcyc);
    exp_t r;
    int vcyc;
    vcyc = tcyc + 1 + L;
    case (mode)
      1: begin
        mode = 2;
        match = 0;
      end
      2: begin
        r = '{pv: 1'b1, er: 1'b0, hp: gap, ec: m_ec, lk: 1'b0, cyc: vcyc};
        sb.push_back(r);
        m_hp = gap;
        if (in_window(gap)) begin
          match++;
          if (match >= LC) mode = 3;
        end else begin
          match = 0;
        end
      end
      3: begin
        if (gap > EXP + TOL) begin
          // held too long: timeout first, then this edge restarts acquisition
          m_ec = sat_inc(m_ec);
          r = '{pv: 1'b0, er: 1'b1, hp: m_hp, ec: m_ec, lk: 1'b1,
                cyc: last_t + 1 + L + EXP + TOL};
          sb.push_back(r);
          mode = 2;
          match = 0;
        end else if (in_window(gap)) begin
          r = '{pv: 1'b1, er: 1'b0, hp: gap, ec: m_ec, lk: 1'b1, cyc: vcyc};
          sb.push_back(r);
          m_hp = gap;
        end else begin
          m_ec = sat_inc(m_ec);
          r = '{pv: 1'b1, er: 1'b1, hp: gap, ec: m_ec, lk: 1'b1, cyc: vcyc};
          sb.push_back(r);
          m_hp = gap;
          mode = 2;
          match = 0;
        end
      end
      default: ;
    endcase
    last_t = tcyc;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tog(input int n);
    model_edge(cyc + n - last_t, cyc + n);
    tick(n);
    toggle_in = ~toggle_in;
  endtask

  task automatic set_en(input bit v);
    en = v;
    if (!v) begin
      mode = 0;
      match = 0;
    end else if (mode == 0) begin
      mode = 1;
    end
  endtask

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops one expected record per DUT output event.
  always @(negedge clk) begin
    exp_t r;
    if (rst_n && (period_valid || err)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: pv=%0d err=%0d hp=%0d at cycle %0d, nothing expected",
                 period_valid, err, half_period, cyc);
      end else begin
        r = sb.pop_front();
        if (r.pv != period_valid || r.er != err || r.hp != int'(half_period) ||
            r.ec != int'(err_count) || r.lk != locked || r.cyc != cyc) begin
          fails++;
          $display("FAIL sb_record: got pv=%0d err=%0d hp=%0d ec=%0d lk=%0d cyc=%0d expected pv=%0d err=%0d hp=%0d ec=%0d lk=%0d cyc=%0d",
                   period_valid, err, half_period, err_count, locked, cyc,
                   r.pv, r.er, r.hp, r.ec, r.lk, r.cyc);
        end
      end
    end
  end

  initial begin
    int r;
    // reset with toggle_in moving
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      toggle_in = ~toggle_in;
      tick(1);
    end
    @(negedge clk);
    check("rst_half_period", int'(half_period), 0);
    check("rst_period_valid", int'(period_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_count", int'(err_count), 0);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    last_t = cyc;

    // steady 10-cycle toggling: lock after the 4th measurement
    set_en(1'b1);
    tick(3);
    for (int i = 0; i < 9; i++) tog(10);
    tick(4);
    check("locked_steady", int'(locked), 1);

    // short half-period while locked, then relock
    tog(6);
    for (int i = 0; i < 5; i++) tog(10);
    // a 13-cycle half-period times out before its edge arrives
    tog(13);
    for (int i = 0; i < 5; i++) tog(10);
    // held well past the timeout, then resume; window edges 9 and 11
    tog(25);
    tog(10); tog(9); tog(11); tog(10); tog(11); tog(9); tog(8);
    for (int i = 0; i < 5; i++) tog(10);
    tick(4);
    check("locked_relock", int'(locked), 1);

    // disable mid-period
    tick(2);
    set_en(1'b0);
    tick(1);
    check("en_off_locked", int'(locked), 0);
    check("en_off_half_period", int'(half_period), m_hp);
    tick(3);
    check("en_off_err_count", int'(err_count), m_ec);
    set_en(1'b1);
    tick(3);

    // randomized half-periods with occasional disables
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        tick(6);
        set_en(1'b0);
        tick($urandom_range(1, 5));
        set_en(1'b1);
        tick(3);
      end else if (r < 5) begin
        tog($urandom_range(1, 8));
      end else if (r < 9) begin
        tog($urandom_range(12, 25));
      end else begin
        tog($urandom_range(9, 11));
      end
    end

    // force enough errors to saturate the counter
    for (int i = 0; i < 270; i++) begin
      for (int k = 0; k < 8 && mode != 3; k++) tog(10);
      if ($urandom_range(0, 1) == 1) tog($urandom_range(1, 8));
      else tog($urandom_range(12, 20));
    end
    tick(40);
    check("err_count_saturated", int'(err_count), 255);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
